// File: rtl/sampler_pkg.sv
// Shared types and constants for the constrained-random sample controller.
// Used by constraint_sample_ctrl and sampler_lfsr.
package sampler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GEN   = 3'd1,
      ST_CHECK = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FAIL  = 3'd4
   } sampler_state_e;

   // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
   localparam logic [31:0] LFSR_RST_VAL  = 32'h0000_0001;
   localparam int          VEC_W_DEFAULT = 320;

endpackage

// File: rtl/sampler_lfsr.sv
// 32-bit Galois LFSR word source for candidate generation.
// A zero seed is substituted with LFSR_RST_VAL so the register never locks up.
module sampler_lfsr
   import sampler_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] q
);

   logic [31:0] q_q;
   logic [31:0] q_d;

   function automatic logic [31:0] galois_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = (seed == 32'h0) ? LFSR_RST_VAL : seed;
      end else if (step) begin
         q_d = galois_step(q_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= LFSR_RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/constraint_sample_ctrl.sv
// Rejection-sampling controller: builds VEC_W-bit candidates from an LFSR, waits for an
// external checker verdict and hands accepted samples out over valid/ready.
// Optional feature macro: SAMPLER_STATS_EN adds the saturating total_tries counter output.
module constraint_sample_ctrl
   import sampler_pkg::*;
#(
   parameter int VEC_W     = VEC_W_DEFAULT,
   parameter int MAX_TRIES = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      num_samples,
   input  logic             seed_load,
   input  logic [31:0]      seed,
   output logic [VEC_W-1:0] cand,
   input  logic             check_ok,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic [VEC_W-1:0] sample_data,
   output logic             busy,
   output logic             done,
   output logic             fail
`ifdef SAMPLER_STATS_EN
   ,
   output logic [31:0]      total_tries
`endif
);

   localparam int WORDS = VEC_W / 32;
   localparam int GEN_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   localparam logic [GEN_W-1:0] GEN_LAST = GEN_W'(WORDS - 1);
   localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_GEN   = ST_GEN;
   localparam logic [2:0] S_CHECK = ST_CHECK;
   localparam logic [2:0] S_HOLD  = ST_HOLD;
   localparam logic [2:0] S_FAIL  = ST_FAIL;

   logic [2:0]       state_q,   state_d;
   logic [VEC_W-1:0] cand_q,    cand_d;
   logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
   logic [TRY_W-1:0] tries_q,   tries_d;
   logic [15:0]      remain_q,  remain_d;
   logic             done_q,    done_d;
   logic             fail_q,    fail_d;

   logic [31:0] lfsr_word;
   logic        lfsr_load;
   logic        lfsr_step;

   // Seed load is only honoured in IDLE; a simultaneous start then sees the new seed in GEN.
   assign lfsr_load = (state_q == S_IDLE) && seed_load;
   assign lfsr_step = (state_q == S_GEN);

   sampler_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load),
      .seed  (seed),
      .step  (lfsr_step),
      .q     (lfsr_word)
   );

   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      gen_cnt_d = gen_cnt_q;
      tries_d   = tries_q;
      remain_d  = remain_q;
      done_d    = 1'b0;
      fail_d    = fail_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               fail_d = 1'b0;
               if (num_samples == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = S_GEN;
                  remain_d  = num_samples;
                  tries_d   = '0;
                  gen_cnt_d = '0;
               end
            end
         end
         S_GEN: begin
            // Oldest word ends up in the top bits after WORDS shifts.
            cand_d = (cand_q << 32) | VEC_W'(lfsr_word);
            if (gen_cnt_q == GEN_LAST) begin
               gen_cnt_d = '0;
               state_d   = S_CHECK;
            end else begin
               gen_cnt_d = gen_cnt_q + 1'b1;
            end
         end
         S_CHECK: begin
            if (check_ok) begin
               state_d = S_HOLD;
            end else begin
               tries_d = tries_q + 1'b1;
               if (tries_q == TRY_LAST) begin
                  state_d = S_FAIL;
                  fail_d  = 1'b1;
               end else begin
                  state_d = S_GEN;
               end
            end
         end
         S_HOLD: begin
            if (sample_ready) begin
               tries_d = '0;
               if (remain_q <= 16'd1) begin
                  remain_d = 16'd0;
                  state_d  = S_IDLE;
                  done_d   = 1'b1;
               end else begin
                  remain_d = remain_q - 16'd1;
                  state_d  = S_GEN;
               end
            end
         end
         S_FAIL: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cand_q    <= '0;
         gen_cnt_q <= '0;
         tries_q   <= '0;
         remain_q  <= 16'd0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         gen_cnt_q <= gen_cnt_d;
         tries_q   <= tries_d;
         remain_q  <= remain_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
      end
   end

   assign cand         = cand_q;
   assign sample_data  = cand_q;
   assign sample_valid = (state_q == S_HOLD);
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign fail         = fail_q;

`ifdef SAMPLER_STATS_EN
   logic [31:0] tot_q;
   logic [31:0] tot_d;

   always_comb begin
      tot_d = tot_q;
      if ((state_q == S_IDLE) && start) begin
         tot_d = 32'd0;
      end else if ((state_q == S_CHECK) && (tot_q != 32'hFFFF_FFFF)) begin
         tot_d = tot_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tot_q <= 32'd0;
      end else begin
         tot_q <= tot_d;
      end
   end

   assign total_tries = tot_q;
`endif

endmodule

// File: tb/tb_constraint_sample_ctrl.sv
// Randomized bench for constraint_sample_ctrl (VEC_W=64, MAX_TRIES=4) against a queue-based
// rejection-sampling model; define SAMPLER_STATS_EN to also cover total_tries.
module tb_constraint_sample_ctrl;

   localparam int VEC_W     = 64;
   localparam int MAX_TRIES = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [15:0]      num_samples;
   logic             seed_load;
   logic [31:0]      seed;
   logic [VEC_W-1:0] cand;
   logic             check_ok;
   logic             sample_valid;
   logic             sample_ready;
   logic [VEC_W-1:0] sample_data;
   logic             busy;
   logic             done;
   logic             fail;
`ifdef SAMPLER_STATS_EN
   logic [31:0]      total_tries;
`endif

   int               n_checks = 0;
   int               n_errors = 0;
   int               mode;
   logic [63:0]      target;
   logic [31:0]      m_lfsr;
   int               m_total;
   logic [63:0]      got_q[$];

   always #5 clk = ~clk;

   constraint_sample_ctrl #(.VEC_W(VEC_W), .MAX_TRIES(MAX_TRIES)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .num_samples  (num_samples),
      .seed_load    (seed_load),
      .seed         (seed),
      .cand         (cand),
      .check_ok     (check_ok),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .busy         (busy),
      .done         (done),
      .fail         (fail)
`ifdef SAMPLER_STATS_EN
      ,
      .total_tries  (total_tries)
`endif
   );

   // Constraint checker: 0 = low two bits nonzero, 1 = accept all, 2 = reject all, 3 = match target
   function automatic bit pred(input logic [63:0] c, input int md, input logic [63:0] tgt);
      case (md)
         1:       return 1'b1;
         2:       return 1'b0;
         3:       return c == tgt;
         default: return c[1:0] != 2'b00;
      endcase
   endfunction

   assign check_ok = pred(cand, mode, target);

   function automatic logic [31:0] m_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // dly < 0 picks a random hold time per sample; otherwise sample_ready waits dly cycles.
   task automatic run(input bit ld, input logic [31:0] sd, input int num, input int md,
                      input int dly, input bit disturb, output int first_cyc, output int busy_cyc);
      logic [63:0] exp_q[$];
      logic [63:0] c;
      logic [63:0] hold_val;
      bit          exp_fail;
      bit          timeout;
      int          tries, idx, wait_c, dly_cur, done_cnt;

      if (ld) m_lfsr = (sd == 32'h0) ? 32'h1 : sd;
      exp_fail = 1'b0;
      tries    = 0;
      m_total  = 0;
      c        = '0;
      while (exp_q.size() < num && !exp_fail) begin
         for (int w = 0; w < VEC_W / 32; w++) begin
            c      = {c[31:0], m_lfsr};
            m_lfsr = m_step(m_lfsr);
         end
         m_total++;
         if (pred(c, md, target)) begin
            exp_q.push_back(c);
            tries = 0;
         end else begin
            tries++;
            if (tries == MAX_TRIES) exp_fail = 1'b1;
         end
      end

      mode        = md;
      got_q.delete();
      seed_load   = ld;
      seed        = sd;
      num_samples = 16'(num);
      start       = 1'b1;
      tick();
      start     = 1'b0;
      seed_load = 1'b0;

      idx = 0; wait_c = 0; done_cnt = 0; busy_cyc = 0; first_cyc = -1;
      hold_val = '0;
      timeout  = 1'b1;
      dly_cur  = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      for (int t = 0; t < 2000; t++) begin
         if (done) done_cnt++;
         if (!busy) begin
            timeout = 1'b0;
            break;
         end
         busy_cyc++;
         sample_ready = 1'b0;
         start        = 1'b0;
         seed_load    = 1'b0;
         if (sample_valid) begin
            if (first_cyc < 0) first_cyc = t + 1;
            if (wait_c == 0) begin
               got_q.push_back(sample_data);
               if (idx < exp_q.size()) chk("sample_data", sample_data, exp_q[idx]);
               else chk("extra_sample", 64'(idx), 64'(exp_q.size()));
               hold_val = sample_data;
            end else begin
               chk("hold_stable", sample_data, hold_val);
            end
            if (wait_c >= dly_cur) begin
               sample_ready = 1'b1;
               idx++;
               wait_c  = 0;
               dly_cur = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            end else begin
               wait_c++;
            end
         end
         if (disturb && $urandom_range(0, 2) == 0) begin
            start       = 1'b1;
            seed_load   = 1'b1;
            seed        = $urandom;
            num_samples = 16'($urandom);
         end
         tick();
      end
      start        = 1'b0;
      seed_load    = 1'b0;
      sample_ready = 1'b0;

      chk("run_timeout", 64'(timeout), 64'd0);
      chk("n_samples", 64'(idx), 64'(exp_q.size()));
      chk("fail_flag", 64'(fail), 64'(exp_fail));
      tick();
      if (done) done_cnt++;
      chk("done_pulses", 64'(done_cnt), exp_fail ? 64'd0 : 64'd1);
      chk("busy_after", 64'(busy), 64'd0);
`ifdef SAMPLER_STATS_EN
      chk("total_tries", 64'(total_tries), 64'(m_total));
`endif
   endtask

   initial begin
      int          fc, bc;
      logic [63:0] s0[$];
      logic [31:0] tl;
      logic [63:0] tc;
      bit          seen;

      rst_n = 1'b0; start = 1'b0; num_samples = '0; seed_load = 1'b0; seed = '0;
      sample_ready = 1'b0; mode = 1; target = '0;
      m_lfsr = 32'h1;
      repeat (3) tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(sample_valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_fail", 64'(fail), 64'd0);
      chk("rst_cand", cand, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Latency with seed 1 and an always-accepting checker.
      run(1'b1, 32'h1, 1, 1, 0, 1'b0, fc, bc);
      chk("first_valid_cycle", 64'(fc), 64'd4);
      chk("seed1_cand", got_q.size() > 0 ? got_q[0] : 64'hx, 64'h0000_0001_8020_0003);

      // Every candidate rejected: 4 tries of 3 cycles, then one FAIL cycle.
      run(1'b0, 32'h0, 2, 2, 0, 1'b0, fc, bc);
      chk("fail_busy_cycles", 64'(bc), 64'd13);

      // Zero-length start: done next cycle, fail cleared.
      num_samples = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_fail_clr", 64'(fail), 64'd0);
      tick();
      chk("zero_done_once", 64'(done), 64'd0);

      // Three samples, each held five cycles before ready.
      run(1'b0, 32'h0, 3, 1, 5, 1'b0, fc, bc);

      // Zero seed behaves as seed 1.
      run(1'b1, 32'h0, 2, 1, 0, 1'b0, fc, bc);
      s0 = got_q;
      run(1'b1, 32'h1, 2, 1, 0, 1'b0, fc, bc);
      for (int i = 0; i < 2; i++)
         chk("seed0_vs_seed1", (i < s0.size()) ? s0[i] : 64'hx, (i < got_q.size()) ? got_q[i] : 64'h0);

      // Two rejects then an accept: target is the third candidate from seed 0xACE1.
      tl = 32'hACE1;
      tc = '0;
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < VEC_W / 32; w++) begin
            tc = {tc[31:0], tl};
            tl = m_step(tl);
         end
      end
      target = tc;
      run(1'b1, 32'hACE1, 1, 3, 0, 1'b0, fc, bc);
`ifdef SAMPLER_STATS_EN
      chk("stats_two_rejects", 64'(total_tries), 64'd3);
`endif

      // Random runs with start/seed_load noise while busy.
      for (int r = 0; r < 8; r++) begin
         run(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(1, 4)), 0, -1, 1'b1, fc, bc);
      end

      // Reset in the middle of HOLD.
      mode = 1;
      num_samples = 16'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 50; t++) begin
         if (sample_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk("hold_reached", 64'(seen), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 64'(sample_valid), 64'd0);
      chk("async_busy", 64'(busy), 64'd0);
      chk("async_cand", cand, 64'd0);
      m_lfsr = 32'h1;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run(1'b0, 32'h0, 2, 1, -1, 1'b0, fc, bc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
